// File: rtl/multi_cycle_ctrl_pkg.sv
// multi_cycle_ctrl_pkg: opcode, funct, ALU, write-back, next-PC and state encodings shared by the controller.
package multi_cycle_ctrl_pkg;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_TIPOR  = 7'b0110011;
  localparam logic [6:0] OP_TIPOU  = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JUMP   = 7'b1101111;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SLT = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [1:0] ORIG_ALU = 2'd0;
  localparam logic [1:0] ORIG_MEM = 2'd1;
  localparam logic [1:0] ORIG_PC4 = 2'd2;
  localparam logic [1:0] ORIG_LUI = 2'd3;
  localparam logic [1:0] PC4   = 2'd0;
  localparam logic [1:0] PCBEQ = 2'd1;
  localparam logic [1:0] PCIMM = 2'd2;
  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_TIPOR, OP_TIPOU, OP_BRANCH, OP_JUMP};
  endfunction
endpackage

// File: rtl/alu_decode.sv
// alu_decode: maps opcode/funct3/funct7 to the ALU operation driven during EXEC.
module alu_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] alu_ctrl_o
);
  logic [3:0] r_op;
  always_comb begin
    r_op = ALU_ADD;
    case (funct3_i)
      F3_ADD:  r_op = funct7_i == F7_SUB ? ALU_SUB : ALU_ADD;
      F3_SLT:  r_op = ALU_SLT;
      F3_OR:   r_op = ALU_OR;
      F3_AND:  r_op = ALU_AND;
      default: r_op = ALU_ADD;
    endcase
  end
  assign alu_ctrl_o = opcode_i == OP_BRANCH ? ALU_SUB : opcode_i == OP_TIPOR ? r_op : ALU_ADD;
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: Moore control FSM for a multi-cycle RISC-V style datapath.
// Define MEM_HANDSHAKE_EN to stall FETCH/MEM on mem_ready with a WAIT_LIMIT timeout into TRAP.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  OrigWriteData,
  output logic [1:0]  OrigPC,
  output logic        OrigALU,
  output logic [3:0]  ALUControl,
  output logic [2:0]  state,
  output logic        fault
);
  state_t     state_q;
  logic [6:0] op_q, f7_q;
  logic [2:0] f3_q;
  logic [3:0] alu_ctrl;
  logic       mem_ok, timeout, unused_ok;
  logic       is_ld, is_st, is_r, is_u, is_br, is_j;
  assign is_ld = op_q == OP_LOAD;
  assign is_st = op_q == OP_STORE;
  assign is_r  = op_q == OP_TIPOR;
  assign is_u  = op_q == OP_TIPOU;
  assign is_br = op_q == OP_BRANCH;
  assign is_j  = op_q == OP_JUMP;
`ifdef MEM_HANDSHAKE_EN
  localparam int WW = $clog2(WAIT_LIMIT + 1);
  logic [WW-1:0] wait_q;
  logic          stall;
  assign stall   = !mem_ready && (state_q == FETCH || state_q == MEM);
  assign mem_ok  = mem_ready;
  assign timeout = stall && wait_q == WW'(WAIT_LIMIT);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) wait_q <= '0;
    else wait_q <= (stall && !timeout) ? wait_q + 1'b1 : '0;
  assign unused_ok = ^{instruction[24:15], instruction[11:7]};
`else
  assign mem_ok    = 1'b1;
  assign timeout   = 1'b0;
  assign unused_ok = ^{instruction[24:15], instruction[11:7], mem_ready, 1'(WAIT_LIMIT)};
`endif
  alu_decode u_alu (
    .opcode_i   (op_q),
    .funct3_i   (f3_q),
    .funct7_i   (f7_q),
    .alu_ctrl_o (alu_ctrl)
  );
  // Opcode fields are captured in DECODE so later instruction changes cannot redirect the sequence
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= FETCH;
      op_q    <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
    end else if (timeout) begin
      state_q <= TRAP;
    end else begin
      case (state_q)
        FETCH:   state_q <= mem_ok ? DECODE : FETCH;
        DECODE: begin
          op_q    <= instruction[6:0];
          f3_q    <= instruction[14:12];
          f7_q    <= instruction[31:25];
          state_q <= is_legal(instruction[6:0]) ? EXEC : TRAP;
        end
        EXEC:    state_q <= (is_ld || is_st) ? MEM : (is_r || is_u) ? WB : FETCH;
        MEM:     state_q <= !mem_ok ? MEM : is_ld ? WB : FETCH;
        WB:      state_q <= FETCH;
        default: state_q <= TRAP;
      endcase
    end
  // Enables are gated by reset_n so they drop the moment reset asserts
  always_comb begin
    PCWrite       = 1'b0;
    IRWrite       = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    RegWrite      = 1'b0;
    OrigWriteData = ORIG_ALU;
    OrigPC        = PC4;
    OrigALU       = 1'b0;
    ALUControl    = ALU_ADD;
    if (reset_n) begin
      IRWrite       = state_q == FETCH;
      MemRead       = state_q == FETCH || (state_q == MEM && is_ld);
      MemWrite      = state_q == MEM && is_st;
      RegWrite      = state_q == WB || (state_q == EXEC && is_j);
      PCWrite       = (state_q == EXEC && (is_br || is_j)) || (state_q == MEM && is_st && mem_ok) || state_q == WB;
      OrigWriteData = state_q == WB ? (is_ld ? ORIG_MEM : is_r ? ORIG_ALU : ORIG_LUI) :
                      (state_q == EXEC && is_j) ? ORIG_PC4 : ORIG_ALU;
      OrigPC        = state_q != EXEC ? PC4 : is_j ? PCIMM : (is_br && branch_taken) ? PCBEQ : PC4;
      OrigALU       = state_q == EXEC && (is_ld || is_st || is_u);
      ALUControl    = state_q == EXEC ? alu_ctrl : ALU_ADD;
    end
  end
  assign state = state_q;
  assign fault = state_q == TRAP;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: scoreboard bench; a per-instruction reference trace is queued and a monitor compares every cycle.
module tb_multi_cycle_ctrl;
  import multi_cycle_ctrl_pkg::*;
  localparam int WL = 15;
`ifdef MEM_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif
  localparam logic [6:0] OPS [6] = '{OP_LOAD, OP_STORE, OP_TIPOR, OP_TIPOU, OP_BRANCH, OP_JUMP};
  localparam logic [3:0] F3_ALU [8] = '{ALU_ADD, ALU_ADD, ALU_SLT, ALU_ADD, ALU_ADD, ALU_ADD, ALU_OR, ALU_AND};
  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, mr, mw, rw;
    logic [1:0] owd, opc;
    logic       oalu;
    logic [3:0] alu;
    logic       flt;
  } exp_t;
  logic clock, reset_n, branch_taken, mem_ready;
  logic [31:0] instruction;
  logic PCWrite, IRWrite, MemRead, MemWrite, RegWrite, OrigALU, fault;
  logic [1:0] OrigWriteData, OrigPC;
  logic [3:0] ALUControl;
  logic [2:0] state;
  exp_t exp_q[$];
  bit   rdy_q[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  bit   mon_en = 0;
  string cur = "none";

  multi_cycle_ctrl #(.WAIT_LIMIT(WL)) dut (
    .clock(clock), .reset_n(reset_n), .instruction(instruction), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .OrigWriteData(OrigWriteData), .OrigPC(OrigPC),
    .OrigALU(OrigALU), .ALUControl(ALUControl), .state(state), .fault(fault)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  function automatic exp_t out_vec();
    exp_t g;
    g = '{st: state, pcw: PCWrite, irw: IRWrite, mr: MemRead, mw: MemWrite, rw: RegWrite,
          owd: OrigWriteData, opc: OrigPC, oalu: OrigALU, alu: ALUControl, flt: fault};
    return g;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic chk_rst(input string nm);
    chk(nm, 32'(out_vec()), 32'(exp_t'('0)));
  endtask

  always @(negedge clock) begin
    cyc++;
    if (mon_en && reset_n) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL trace %s cycle %0d: DUT produced a cycle with no expectation queued", cur, cyc);
      end else begin
        exp_t e, g;
        e = exp_q.pop_front();
        g = out_vec();
        if (g !== e) begin
          n_fail++;
          $display("FAIL trace %s cycle %0d: got st=%0d pcw=%b irw=%b mr=%b mw=%b rw=%b owd=%0d opc=%0d oalu=%b alu=%0d flt=%b expected st=%0d pcw=%b irw=%b mr=%b mw=%b rw=%b owd=%0d opc=%0d oalu=%b alu=%0d flt=%b",
                   cur, cyc, g.st, g.pcw, g.irw, g.mr, g.mw, g.rw, g.owd, g.opc, g.oalu, g.alu, g.flt,
                   e.st, e.pcw, e.irw, e.mr, e.mw, e.rw, e.owd, e.opc, e.oalu, e.alu, e.flt);
        end
      end
    end
  end

  task automatic put(input exp_t e, input bit r);
    exp_q.push_back(e);
    rdy_q.push_back(r);
  endtask

  // Reference trace: one entry per clock cycle, built from the per-opcode phase rules
  task automatic model(input logic [31:0] ins, input bit tk, input int sf, input int sm, output bit trap);
    logic [6:0] op;
    logic [2:0] f3;
    bit ld, st, r, u, br, j;
    exp_t e;
    op = ins[6:0];
    f3 = ins[14:12];
    ld = op == OP_LOAD; st = op == OP_STORE; r = op == OP_TIPOR;
    u = op == OP_TIPOU; br = op == OP_BRANCH; j = op == OP_JUMP;
    trap = 0;
    rdy_q.delete();
    for (int i = 0; i <= sf && i <= WL; i++) begin
      e = '0; e.st = FETCH; e.mr = 1; e.irw = 1;
      put(e, HS ? (i == sf) : 1'($urandom));
    end
    if (sf > WL) trap = 1;
    else begin
      e = '0; e.st = DECODE;
      put(e, 1'($urandom));
      if (!(ld || st || r || u || br || j)) trap = 1;
      else begin
        e = '0; e.st = EXEC;
        e.oalu = ld || st || u;
        e.alu = br ? ALU_SUB : !r ? ALU_ADD : (f3 == 3'd0 && ins[31:25] == 7'h20) ? ALU_SUB : F3_ALU[f3];
        if (br) begin e.pcw = 1; e.opc = tk ? PCBEQ : PC4; end
        if (j) begin e.pcw = 1; e.opc = PCIMM; e.rw = 1; e.owd = ORIG_PC4; end
        put(e, 1'($urandom));
        if (ld || st) begin
          for (int i = 0; i <= sm && i <= WL; i++) begin
            e = '0; e.st = MEM; e.mr = ld; e.mw = st; e.pcw = st && i == sm;
            put(e, HS ? (i == sm) : 1'($urandom));
          end
          if (sm > WL) trap = 1;
        end
        if (!trap && (ld || r || u)) begin
          e = '0; e.st = WB; e.rw = 1; e.pcw = 1;
          e.owd = ld ? ORIG_MEM : r ? ORIG_ALU : ORIG_LUI;
          put(e, 1'($urandom));
        end
      end
    end
    if (trap)
      for (int i = 0; i < 20; i++) begin
        e = '0; e.st = TRAP; e.flt = 1;
        put(e, 1'($urandom));
      end
  endtask

  task automatic do_reset(input string nm);
    mon_en = 0;
    reset_n = 0;
    #1 chk_rst(nm);
    @(posedge clock); #1;
    exp_q.delete();
    reset_n = 1;
    mon_en = 1;
  endtask

  // Called at posedge+1 of the instruction's first FETCH cycle
  task automatic issue(input string nm, input logic [31:0] ins, input bit tk, input int sf, input int sm, input int abort);
    bit trap;
    int n;
    cur = nm;
    model(ins, tk, sf, sm, trap);
    n = rdy_q.size();
    for (int c = 0; c < n; c++) begin
      instruction  = c <= sf + 1 ? ins : $urandom;
      branch_taken = c == sf + 2 ? tk : 1'($urandom);
      mem_ready    = rdy_q[c];
      if (c == abort) begin
        #1 chk({nm, "_memwrite"}, 32'(MemWrite), 32'd1);
        reset_n = 0;
        #1 chk_rst({nm, "_abort"});
        mon_en = 0;
        exp_q.delete();
        @(posedge clock); #1;
        reset_n = 1;
        mon_en = 1;
        break;
      end
      @(posedge clock); #1;
    end
    if (trap) do_reset({nm, "_trap_reset"});
  endtask

  initial begin
    logic [31:0] ins;
    int pick, sf, sm, ab;
    reset_n = 0; instruction = '0; branch_taken = 0; mem_ready = 0;
    repeat (2) @(posedge clock);
    #1 chk_rst("reset");
    reset_n = 1;
    mon_en = 1;
    issue("add", 32'h002081B3, 0, 0, 0, -1);
    issue("lw", 32'h0000A183, 0, 0, 0, -1);
    issue("sw", 32'h0030A023, 0, 0, 0, -1);
    issue("beq_t", 32'h00208463, 1, 0, 0, -1);
    issue("beq_nt", 32'h00208463, 0, 0, 0, -1);
    issue("jal", 32'h008000EF, 0, 0, 0, -1);
    issue("lui", 32'h123451B7, 0, 0, 0, -1);
    issue("sub", 32'h402081B3, 0, 0, 0, -1);
    issue("slt", 32'h0020A1B3, 0, 0, 0, -1);
    issue("or", 32'h0020E1B3, 0, 0, 0, -1);
    issue("and", 32'h0020F1B3, 0, 0, 0, -1);
    issue("xor_dflt", 32'h0020C1B3, 0, 0, 0, -1);
    issue("illegal", 32'h0000007F, 0, 0, 0, -1);
    issue("sw_rst", 32'h0030A023, 0, 0, 0, 3);
    issue("add_after", 32'h002081B3, 0, 0, 0, -1);
`ifdef MEM_HANDSHAKE_EN
    issue("lw_wait3", 32'h0000A183, 0, 0, 3, -1);
    issue("add_fwait15", 32'h002081B3, 0, 15, 0, -1);
    issue("lw_wait16", 32'h0000A183, 0, 0, 16, -1);
    issue("add_fwait16", 32'h002081B3, 0, 16, 0, -1);
    issue("sw_rst_wait", 32'h0030A023, 0, 1, 2, 4);
`endif
    for (int k = 0; k < 150; k++) begin
      ins  = $urandom;
      pick = $urandom_range(0, 12);
      ins[6:0] = pick == 12 ? ($urandom_range(0, 1) ? 7'h7F : 7'h13) : OPS[pick % 6];
      sf = HS ? $urandom_range(0, 3) : 0;
      sm = HS ? $urandom_range(0, 3) : 0;
      ab = (ins[6:0] == OP_STORE && $urandom_range(0, 7) == 0) ? sf + 3 : -1;
      issue("rand", ins, 1'($urandom), sf, sm, ab);
    end
    mon_en = 0;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15: maximum consecutive memory wait cycles before fault (used only with MEM_HANDSHAKE_EN).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instruction  in  32  instruction register contents.
- branch_taken  in  1  branch comparator result, valid in EXEC.
- mem_ready  in  1  memory access complete (MEM_HANDSHAKE_EN only).
- PCWrite  out  1  PC register load enable.
- IRWrite  out  1  instruction register load enable.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register-file write enable.
- OrigWriteData  out  2  write-back source select.
- OrigPC  out  2  next-PC select: PC4, PCBEQ, PCIMM.
- OrigALU  out  1  ALU operand B select: register or immediate.
- ALUControl  out  4  ALU operation.
- state  out  3  current FSM state, for debug.
- fault  out  1  sticky: illegal opcode or memory timeout.

Function
REQ-003 SHALL implement Moore FSM states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-004 FETCH SHALL assert MemRead and IRWrite for one cycle, then go to DECODE.
REQ-005 DECODE SHALL assert no write enables; it SHALL go to EXEC for LOAD, STORE, TIPOR, TIPOU, BRANCH and JUMP, and to TRAP for any other opcode.
REQ-006 EXEC SHALL drive ALUControl/OrigALU per opcode:
- LOAD/STORE/TIPOU: ADD, immediate.
- BRANCH: SUB, register.
- TIPOR: funct3 decode (ADD, or SUB when funct7=0100000; SLT, OR, AND; default ADD), register.
REQ-007 From EXEC: LOAD and STORE SHALL go to MEM; TIPOR and TIPOU SHALL go to WB; BRANCH and JUMP SHALL go to FETCH.
REQ-008 PCWrite SHALL assert exactly once per instruction, with OrigPC selecting the source:
- BRANCH: in EXEC, OrigPC=PCBEQ if branch_taken, else PC4.
- JUMP: in EXEC, OrigPC=PCIMM.
- All others: in their final state, OrigPC=PC4.
REQ-009 JUMP EXEC SHALL also assert RegWrite with OrigWriteData=ORIG_PC4.
REQ-010 MEM:
- LOAD: assert MemRead, then go to WB.
- STORE: assert MemWrite, then go to FETCH.
REQ-011 WB SHALL assert RegWrite with OrigWriteData set to ORIG_MEM for LOAD, ORIG_ALU for TIPOR, and ORIG_LUI for TIPOU, then go to FETCH.
REQ-012 Latency in cycles SHALL be: LOAD 5; STORE, TIPOR, TIPOU 4; BRANCH, JUMP 3.
REQ-013 TRAP SHALL hold all enables low and set fault; it SHALL exit only via reset.
REQ-014 Any output not named active for a state SHALL be 0.
REQ-015 An opcode change after DECODE SHALL not affect the state sequence; the opcode SHALL be latched in DECODE.

Reset
REQ-016 reset_n low SHALL immediately force FETCH, clear fault and latched opcode, and drive all enables to 0, including mid-MEM or mid-wait.
REQ-017 The first FETCH SHALL occur in the first rising edge cycle after reset_n deasserts.

Configuration
REQ-018 With MEM_HANDSHAKE_EN defined:
- FETCH and MEM SHALL hold their strobes and remain in place until mem_ready=1.
- A wait counter SHALL count consecutive stall cycles and reset on state exit.
- After WAIT_LIMIT stall cycles, the FSM SHALL go to TRAP.
REQ-019 Without MEM_HANDSHAKE_EN, mem_ready SHALL be ignored, memory SHALL be treated as single-cycle, and no counter SHALL be built.

Structure
REQ-020 Opcode, funct3, ALU_*, ORIG_*, PC* and state encodings SHALL live in the shared params package.
REQ-021 Sub-module alu_decode SHALL be the combinational decoder from opcode/funct3/funct7 to ALUControl.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- add x3,x1,x2 (0x002081B3) -> states FETCH,DECODE,EXEC,WB; RegWrite in cycle 4 only; ALUControl=ALU_ADD.
- lw, then sw -> 5 and 4 cycles; MemRead in MEM for lw; MemWrite in MEM for sw; exactly one PCWrite each.
- beq with branch_taken=1, then beq with branch_taken=0 -> 3 cycles each; OrigPC=PCBEQ, then PC4.
- Opcode 0x7F -> TRAP after DECODE, fault=1, all enables 0 for 20 cycles.
- MEM_HANDSHAKE_EN with mem_ready low for 3 cycles -> lw takes 8 cycles; mem_ready low for 16 cycles -> TRAP.
- reset_n pulsed low during MEM of sw -> MemWrite drops asynchronously; FSM restarts in FETCH.
